// File: rtl/stream_elastic_fifo.sv
// Elastic valid/ready FIFO with optional fall-through when empty.
// Occupancy tracked as EMPTY/PARTIAL/FULL beside an explicit usage count.
module stream_elastic_fifo #(
  parameter int unsigned Depth       = 4,
  parameter bit          FallThrough = 1'b0,
  parameter type         payload_t   = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  payload_t                   payload_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output payload_t                   payload_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(Depth+1)-1:0] usage_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] NearCnt = CntW'(Depth - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;

  payload_t mem [Depth];

  logic block;
  logic bypass;
  logic push;
  logic pop;
  logic store;
  logic fetch;

  assign block  = clr_i | rst_i;
  assign bypass = FallThrough && (state_q == EMPTY);

  assign ready_o = (state_q != FULL) && !block;
  assign valid_o = ((state_q != EMPTY) || (FallThrough && valid_i))
                   && !block;

  assign payload_o = bypass ? payload_i : mem[rptr_q];

  assign push = valid_i && ready_o;
  assign pop  = valid_o && ready_i;

  // A word that bypasses an empty buffer and is taken at once never lands.
  assign store = push && !(bypass && pop);
  assign fetch = pop && !bypass;

  assign usage_o = cnt_q;
  assign full_o  = (state_q == FULL);
  assign empty_o = (state_q == EMPTY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (clr_i) begin
      state_d = EMPTY;
      cnt_d   = '0;
      wptr_d  = '0;
      rptr_d  = '0;
    end else begin
      if (store) begin
        wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      end
      if (fetch) begin
        rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      end
      unique case ({store, fetch})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
      unique case (state_q)
        EMPTY: begin
          if (store) state_d = PARTIAL;
        end
        PARTIAL: begin
          if (store && !fetch && cnt_q == NearCnt) begin
            state_d = FULL;
          end else if (fetch && !store && cnt_q == OneCnt) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fetch) state_d = PARTIAL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (store) begin
      mem[wptr_q] <= payload_i;
    end
  end

endmodule

// File: doc/stream_elastic_fifo.md
STREAM_ELASTIC_FIFO -- requirements
Module: stream_elastic_fifo

Interface
REQ-001 SHALL provide parameter Depth, default 4, number of storage entries; legal range 2..16, non-power-of-two allowed.
REQ-002 SHALL provide parameter FallThrough, default 0; 1 = an empty buffer forwards input to output in the same cycle.
REQ-003 SHALL provide parameter payload_t, default logic, type of the carried payload.
REQ-004 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clr_i  input  1  synchronous clear, active high.
REQ-007 SHALL have port payload_i  input  payload_t  upstream payload.
REQ-008 SHALL have port valid_i  input  1  upstream valid.
REQ-009 SHALL have port ready_o  output  1  upstream ready.
REQ-010 SHALL have port payload_o  output  payload_t  downstream payload, feeding the delay stage.
REQ-011 SHALL have port valid_o  output  1  downstream valid.
REQ-012 SHALL have port ready_i  input  1  downstream ready.
REQ-013 SHALL have port usage_o  output  $clog2(Depth+1)  entries currently stored.
REQ-014 SHALL have ports full_o and empty_o  output  1 each  usage_o==Depth and usage_o==0, respectively.

Function
REQ-015 SHALL define push = valid_i && ready_o and pop = valid_o && ready_i.
REQ-016 SHALL drive ready_o = (usage_o < Depth) && !clr_i && !rst_i; there is no pass-through when full.
REQ-017 SHALL drive valid_o = (usage_o > 0) || (FallThrough && valid_i), forced 0 while clr_i or rst_i is high.
REQ-018 SHALL present the oldest stored entry on payload_o when usage_o > 0, else payload_i when FallThrough=1.
REQ-019 SHALL deliver entries in strict push order, with no loss, duplication or reordering.
REQ-020 SHALL, with FallThrough=0, show a word pushed at edge N on valid_o/payload_o from edge N onward (1-cycle latency).
REQ-021 SHALL, with FallThrough=1 while empty, pass valid_i/payload_i through combinationally; a push popped in the same cycle is not stored and usage_o stays 0.
REQ-022 SHALL update usage_o at each edge: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
REQ-023 SHALL keep write and read pointers in 0..Depth-1, wrapping from Depth-1 to 0 on push or pop respectively.
REQ-024 SHALL hold payload_o and valid_o stable while valid_o && !ready_i, except when clr_i or rst_i is asserted.
REQ-025 SHALL operate in occupancy states EMPTY (usage_o=0), PARTIAL, and FULL (usage_o=Depth): EMPTY->PARTIAL on push without pop; PARTIAL->FULL on push without pop at usage_o=Depth-1; FULL->PARTIAL on pop; PARTIAL->EMPTY on pop without push at usage_o=1.
REQ-026 SHALL, on clr_i high at an edge, set usage_o=0 and both pointers=0, and discard any concurrent push or pop; clr_i takes priority over all other events.
REQ-027 SHALL sustain one push and one pop per cycle when PARTIAL (full throughput).
REQ-028 SHALL not use ready_i to form ready_o, and SHALL not create combinational ready_i->ready_o or valid_i->ready_o paths.
REQ-029 SHALL leave behaviour undefined only for upstream protocol violations (valid_i or payload_i changing before the handshake).

Reset
REQ-030 SHALL, while rst_i is high, asynchronously force usage_o=0, pointers=0, valid_o=0, ready_o=0, full_o=0 and empty_o=1.
REQ-031 SHALL assert ready_o=1 in the first cycle after rst_i deasserts (Depth>=2).
REQ-032 SHALL not require a reset on the storage array; its contents are unobservable until written.
REQ-033 SHALL abort any in-flight transfer on rst_i assertion mid-operation, with all stored entries lost.

Verification
REQ-034 Fill/drain: Depth=4, ready_i=0, push A,B,C,D -> full_o=1, ready_o=0 and usage_o=4; a fifth valid_i is not accepted; then ready_i=1 -> A,B,C,D pop on 4 consecutive edges and empty_o=1.
REQ-035 Wrap: Depth=3, 10 pushes interleaved with pops at random ready_i -> output sequence equals input sequence, usage_o never exceeds 3.
REQ-036 Simultaneous: usage_o=2, push+pop in the same cycle -> usage_o stays 2 and order is preserved; with FallThrough=1 and empty, push+pop -> payload_o=payload_i in the same cycle and usage_o=0.
REQ-037 Clear: usage_o=3, clr_i pulsed for 1 cycle concurrent with valid_i=1 -> valid_o=0 and ready_o=0 during the pulse; next cycle usage_o=0, empty_o=1, and the concurrent word is absent.
REQ-038 Reset mid-operation: usage_o=2 with valid_o stalled, rst_i asserted asynchronously between edges -> valid_o=0 and usage_o=0 immediately; after release, ready_o=1 and empty_o=1.
REQ-039 Backpressure stability: valid_o=1 with ready_i=0 for 5 cycles -> payload_o unchanged throughout, then handshake completes on the first ready_i=1 edge.
